// File: rtl/prng_multi_iom_if.sv
// MCS IO bus bundle for the multi-channel PRNG peripheral.
// master drives the strobes and address/data; slave answers.
interface prng_multi_iom_if;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [11:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  modport master (
    output io_addr_strobe, io_read_strobe, io_write_strobe,
    output io_address, io_byte_enable, io_write_data,
    input  io_read_data, io_ready
  );

  modport slave (
    input  io_addr_strobe, io_read_strobe, io_write_strobe,
    input  io_address, io_byte_enable, io_write_data,
    output io_read_data, io_ready
  );
endinterface

// File: rtl/prng_multi_iom.sv
// NCHAN xorshift32 generators with prefetch FIFOs on the MCS IO bus.
// Define PRNG_MULTI_IOM_COUNT_EN for per-channel pop counters at +16.
module prng_multi_iom #(
  parameter int NCHAN      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  prng_multi_iom_if.slave bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = 5;
  localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [31:0]   r_seed [NCHAN];
  logic [31:0]   r_x    [NCHAN];
  logic [31:0]   r_mem  [NCHAN][FIFO_DEPTH];
  logic [AW-1:0] r_wp   [NCHAN];
  logic [AW-1:0] r_rp   [NCHAN];
  logic [CW-1:0] r_cnt  [NCHAN];
  logic          r_en   [NCHAN];
  logic          r_pend;
  logic [CHW-1:0] r_pch;
  logic          r_ready;
  logic [31:0]   r_rdata;

  logic [6:0]     w_ch;
  logic [CHW-1:0] w_c;
  logic [4:0]     w_off;
  logic           w_chv, w_acc, w_rd, w_wr, w_stall;
  logic [31:0]    w_rmux, w_cval, w_wdata, w_seedv;
  logic           w_full   [NCHAN];
  logic           w_empty  [NCHAN];
  logic           w_seedwr [NCHAN];
  logic           w_ctrlwr [NCHAN];
  logic           w_push   [NCHAN];
  logic           w_pop    [NCHAN];
  logic [31:0]    w_next   [NCHAN];
  logic [31:0]    w_head   [NCHAN];
  logic           w_unused;

  assign w_unused = ^{bus.io_write_strobe, bus.io_byte_enable};

  assign w_ch    = bus.io_address[11:5];
  assign w_c     = w_ch[CHW-1:0];
  assign w_off   = bus.io_address[4:0];
  assign w_chv   = w_ch < 7'(NCHAN);
  assign w_acc   = bus.io_addr_strobe && !r_pend;
  assign w_rd    = w_acc && bus.io_read_strobe;
  assign w_wr    = w_acc && !bus.io_read_strobe;
  assign w_wdata = bus.io_write_data;
  // Zero is the xorshift fixed point, so it is never stored.
  assign w_seedv = (w_wdata == 32'h0) ? 32'h1 : w_wdata;

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      w_full[c]   = r_cnt[c] == CW'(FIFO_DEPTH);
      w_empty[c]  = r_cnt[c] == '0;
      w_next[c]   = xs(r_x[c]);
      w_head[c]   = r_mem[c][r_rp[c]];
      w_seedwr[c] = w_wr && w_chv && (w_c == CHW'(c)) && (w_off == 5'd0);
      w_ctrlwr[c] = w_wr && w_chv && (w_c == CHW'(c)) && (w_off == 5'd8);
      w_push[c]   = r_en[c] && !w_full[c] && !w_seedwr[c];
      w_pop[c]    = (w_rd && w_chv && (w_c == CHW'(c))
                     && (w_off == 5'd4) && !w_empty[c])
                  || (r_pend && (r_pch == CHW'(c)) && !w_empty[c]);
    end
  end

`ifdef PRNG_MULTI_IOM_COUNT_EN
  logic [31:0] r_pops [NCHAN];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (rst) begin
        r_pops[c] <= '0;
      end else if (w_seedwr[c] || (w_wr && w_chv
                   && (w_c == CHW'(c)) && (w_off == 5'd16))) begin
        r_pops[c] <= '0;
      end else if (w_pop[c]) begin
        r_pops[c] <= r_pops[c] + 32'd1;
      end
    end
  end

  assign w_cval = r_pops[w_c];
`else
  assign w_cval = 32'h0;
`endif

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (rst) begin
        r_seed[c] <= 32'h1;
        r_x[c]    <= 32'h1;
        r_wp[c]   <= '0;
        r_rp[c]   <= '0;
        r_cnt[c]  <= '0;
        r_en[c]   <= 1'b0;
      end else begin
        if (w_seedwr[c]) begin
          r_seed[c] <= w_seedv;
          r_x[c]    <= w_seedv;
          r_wp[c]   <= '0;
          r_rp[c]   <= '0;
          r_cnt[c]  <= '0;
        end else begin
          if (w_push[c]) begin
            r_mem[c][r_wp[c]] <= w_next[c];
            r_x[c]            <= w_next[c];
            r_wp[c]           <= r_wp[c] + 1'b1;
          end
          if (w_pop[c]) r_rp[c] <= r_rp[c] + 1'b1;
          if (w_push[c] && !w_pop[c]) r_cnt[c] <= r_cnt[c] + 5'd1;
          if (!w_push[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - 5'd1;
        end
        if (w_ctrlwr[c]) r_en[c] <= w_wdata[0];
      end
    end
  end

  always_comb begin
    w_rmux = '0;
    if (w_chv) begin
      unique case (1'b1)
        (w_off == 5'd0):  w_rmux = r_seed[w_c];
        (w_off == 5'd4):  w_rmux = w_empty[w_c] ? 32'h0 : w_head[w_c];
        (w_off == 5'd8):  w_rmux = {31'h0, r_en[w_c]};
        (w_off == 5'd12): w_rmux = {22'h0, w_full[w_c], w_empty[w_c],
                                    3'h0, r_cnt[w_c]};
        (w_off == 5'd16): w_rmux = w_cval;
        default:          w_rmux = '0;
      endcase
    end
  end

  assign w_stall = w_rd && w_chv && (w_off == 5'd4)
                && w_empty[w_c] && r_en[w_c];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_pend  <= 1'b0;
      r_pch   <= '0;
    end else begin
      r_ready <= 1'b0;
      if (r_pend) begin
        if (!w_empty[r_pch]) begin
          r_ready <= 1'b1;
          r_rdata <= w_head[r_pch];
          r_pend  <= 1'b0;
        end
      end else if (bus.io_addr_strobe) begin
        if (w_stall) begin
          r_pend <= 1'b1;
          r_pch  <= w_c;
        end else begin
          r_ready <= 1'b1;
          if (w_rd) r_rdata <= w_rmux;
        end
      end
    end
  end

  assign bus.io_ready     = r_ready;
  assign bus.io_read_data = r_rdata;
endmodule

// File: tb/tb_prng_multi_iom.sv
// Bench for prng_multi_iom: vector table through a read scoreboard,
// plus a hand-driven reset-during-stall sequence.
module tb_prng_multi_iom;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prng_multi_iom_if bus();

  prng_multi_iom #(.NCHAN(4), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef PRNG_MULTI_IOM_COUNT_EN
  localparam logic [31:0] CNT5 = 32'd5;
`else
  localparam logic [31:0] CNT5 = 32'd0;
`endif

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] e;
    int          lat;
    int          pre;
    string       nm;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] sbq[$];
  logic [31:0] m[4];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function void addw(logic [11:0] a, logic [31:0] d, int pre, string nm);
    vec_t v;
    v.wr = 1'b1; v.a = a; v.d = d; v.e = '0;
    v.lat = 1; v.pre = pre; v.nm = nm;
    vt.push_back(v);
    if (a[4:0] == 5'd0 && a[11:5] < 7'd4)
      m[a[6:5]] = (d == 32'h0) ? 32'h1 : d;
  endfunction

  function void addr(logic [11:0] a, logic [31:0] e, int lat,
                     int pre, string nm);
    vec_t v;
    v.wr = 1'b0; v.a = a; v.d = '0; v.e = e;
    v.lat = lat; v.pre = pre; v.nm = nm;
    vt.push_back(v);
  endfunction

  function void addrand(int ch, int lat, int pre, string nm);
    logic [31:0] e;
    e = xs(m[ch]);
    m[ch] = e;
    addr(12'(ch * 32 + 4), e, lat, pre, nm);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int n;
    logic [31:0] e;
    repeat (v.pre) @(negedge clk);
    bus.io_addr_strobe  = 1'b1;
    bus.io_read_strobe  = !v.wr;
    bus.io_write_strobe = v.wr;
    bus.io_address      = v.a;
    bus.io_write_data   = v.d;
    if (!v.wr) sbq.push_back(v.e);
    @(negedge clk);
    bus.io_addr_strobe  = 1'b0;
    bus.io_read_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
    n = 1;
    while (!bus.io_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.io_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready", v.nm);
      if (!v.wr) e = sbq.pop_front();
    end else begin
      if (!v.wr) begin
        e = sbq.pop_front();
        chk(v.nm, bus.io_read_data, e);
      end
      if (v.lat != 0) chk({v.nm, "_lat"}, 32'(n), 32'(v.lat));
    end
  endtask

  initial begin
    int order[8];
    logic seen;
    vec_t v;
    order = '{0, 1, 1, 0, 0, 0, 1, 1};
    for (int c = 0; c < 4; c++) m[c] = 32'h1;

    addr(12'h000, 32'h1, 1, 0, "seed0_rst");
    addw(12'h000, 32'h1, 0, "wseed0");
    addw(12'h008, 32'h1, 0, "wctrl0");
    addr(12'h00C, 32'h204, 1, 10, "stat0_full");
    addr(12'h004, 32'h00042021, 1, 0, "rand0_gold");
    m[0] = 32'h00042021;
    for (int k = 0; k < 3; k++) addrand(0, 1, 0, "rand0_seq");
    addw(12'h020, 32'h0, 0, "wseed1_zero");
    addr(12'h020, 32'h1, 1, 0, "seed1_rd");
    addw(12'h028, 32'h1, 0, "wctrl1");
    addr(12'h028, 32'h1, 1, 0, "ctrl1_rd");
    addrand(1, 1, 0, "rand1");
    addw(12'h048, 32'h1, 0, "wctrl2");
    addw(12'h040, 32'h12345678, 0, "wseed2");
    addrand(2, 2, 0, "rand2_stall");
    addr(12'h064, 32'h0, 1, 0, "rand3_dis");
    addr(12'h400, 32'h0, 1, 0, "unmap_rd");
    addw(12'h400, 32'hFFFFFFFF, 0, "unmap_wr");
    addr(12'h080, 32'h0, 1, 0, "chan4_rd");
    addr(12'h034, 32'h0, 1, 0, "unmap_off");
    addr(12'h06C, 32'h100, 1, 0, "stat3_empty");
    addr(12'h000, 32'h1, 1, 0, "seed0_keep");
    addw(12'h000, 32'hDEADBEEF, 0, "wseed0_db");
    addw(12'h020, 32'hDEADBEEF, 0, "wseed1_db");
    for (int k = 0; k < 8; k++) addrand(order[k], 0, 0, "ilv");
    addw(12'h008, 32'h0, 8, "wctrl0_off");
    addr(12'h00C, 32'h204, 1, 3, "stat0_hold");
    addrand(0, 1, 0, "rand0_off");
    addr(12'h00C, 32'h003, 1, 0, "stat0_pop");
    addw(12'h008, 32'h1, 0, "wctrl0_on");
    addw(12'h000, 32'hCAFEF00D, 0, "wseed0_c");
    for (int k = 0; k < 5; k++) addrand(0, 0, 0, "rand0_c");
    addr(12'h010, CNT5, 1, 0, "cnt5");
    addw(12'h010, 32'h0, 0, "wcnt");
    addr(12'h010, 32'h0, 1, 0, "cnt_clr");

    bus.io_addr_strobe  = 1'b0;
    bus.io_read_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
    bus.io_address      = '0;
    bus.io_byte_enable  = 4'hF;
    bus.io_write_data   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, bus.io_ready}, 32'h0);
    chk("rst_data", bus.io_read_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) do_op(vt[i]);

    // Stall on ch3, then reset before the word arrives.
    v.wr = 1'b1; v.a = 12'h068; v.d = 32'h1; v.e = '0;
    v.lat = 1; v.pre = 0; v.nm = "wctrl3";
    do_op(v);
    bus.io_addr_strobe = 1'b1;
    bus.io_read_strobe = 1'b1;
    bus.io_address     = 12'h064;
    @(negedge clk);
    bus.io_addr_strobe = 1'b0;
    bus.io_read_strobe = 1'b0;
    chk("pend_noready", {31'h0, bus.io_ready}, 32'h0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.io_ready;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bus.io_ready;
    end
    chk("rst_abandon", {31'h0, seen}, 32'h0);
    v.wr = 1'b0; v.a = 12'h06C; v.e = 32'h100; v.nm = "stat3_rst";
    do_op(v);
    v.a = 12'h068; v.e = 32'h0; v.nm = "ctrl3_rst";
    do_op(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prng_multi_iom.md
Name: prng_multi_iom

Overview:
- Multi-channel PRNG peripheral on the MicroBlaze MCS IO bus, replacing the single-generator PRNG IO module.
- NCHAN independent xorshift32 generators, each with its own seed, enable and prefetch FIFO.
- Random reads are normally served in one cycle from prefetched values.
- Sits on the IO bus beside the other peripheral IO modules; the address decode in front of it supplies io_address relative to the block base.

Parameters:
- NCHAN, 4: number of generator channels, legal 1..16.
- FIFO_DEPTH, 4: prefetch words per channel, power of two, legal 2..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- io_addr_strobe  in  1  bus transaction start
- io_read_strobe  in  1  read when high at strobe, else write
- io_write_strobe  in  1  write qualifier (decode uses io_read_strobe only)
- io_address  in  12  byte offset within block
- io_byte_enable  in  4  ignored; all writes are full 32-bit
- io_write_data  in  32  write data
- io_read_data  out  32  read data, valid while io_ready=1
- io_ready  out  1  one-cycle transaction completion pulse

Behaviour:
- Reset (rst=1 at clk edge): all seeds=32'h1, generator states=32'h1, FIFOs empty, enables=0, io_ready=0, io_read_data=0, no pending transaction. Reset mid-transaction abandons it with no io_ready.
- Map: channel c base = c*32. +0 SEED (RW), +4 RAND (RO, pops), +8 CTRL (RW, bit0=enable), +12 STATUS (RO: [4:0]=fifo count, bit8=empty, bit9=full), +16 COUNT (see optional feature).
- Unmapped offset or channel>=NCHAN: read returns 0, write ignored, io_ready after 1 cycle.
- Generator step: x^=x<<13; x^=x>>17; x^=x<<5, all 32-bit. Each step pushes the new x into the FIFO.
- Generator steps once per cycle while enable=1 and FIFO not full. If a pop and a push coincide, both occur and the count is unchanged.
- SEED write: seed=data, except data 0 stores 32'h1 (avoids the xorshift lockup state). State is reloaded from seed and the FIFO is flushed, both in the same cycle.
- SEED read returns the stored seed.
- Transaction latency: io_ready and data are presented in the cycle after the strobe. Exception: a RAND read while the FIFO is empty.
- RAND read with FIFO empty, enable=1: the transaction is held pending. io_ready is asserted the cycle after the first push, with that word; the word is popped.
- RAND read with FIFO empty, enable=0: returns 0 with io_ready after 1 cycle; no stall.
- A new strobe during a pending transaction is not permitted (the MCS bus guarantees this). Behaviour in that case is undefined.
- Disabling a channel (CTRL bit0=0) keeps FIFO contents; reads still pop them.
- io_read_data holds its last value when io_ready=0.

Optional Feature:
- Macro: PRNG_MULTI_IOM_COUNT_EN.
- Defined: each channel has a 32-bit counter of successful RAND pops, readable at +16, wrapping 0xFFFFFFFF->0. Any write to +16 clears it. A SEED write also clears it.
- Undefined: +16 behaves as unmapped (reads 0, writes ignored); no counter logic is synthesised.

Test Plan:
- Reset, write SEED ch0=1, CTRL ch0=1, wait 10 cycles, read STATUS ch0 -> count=FIFO_DEPTH, full=1. Then RAND read -> 0x00042021 with io_ready 1 cycle after strobe; next 3 reads match the golden xorshift32 sequence.
- Write SEED ch1=0, read SEED ch1 -> 0x00000001. Enable ch1, then RAND ch1 -> 0x00042021.
- Enable ch2, seed it, then immediately RAND read ch2 -> io_ready delayed until the first push (2 cycles after strobe); value = first step of the seed.
- Read RAND ch3 with enable=0 and FIFO empty -> 0 after 1 cycle. Read address 0x400 -> 0. Write 0x400 -> no state change.
- Seed ch0=0xDEADBEEF and ch1=0xDEADBEEF, both enabled; interleave 8 reads -> identical per-channel sequences, independent of interleave order.
- With PRNG_MULTI_IOM_COUNT_EN: 5 RAND pops ch0 -> +16 reads 5. Write +16 -> reads 0. Without the macro: +16 always reads 0.
